wb_collector: RTL and testbench
===============================

Name: wb_collector

Overview:
- Writeback collector directly downstream of the execute stage.
- Captures the result streams the execute stage produces: FLU, load, store, FPU and CoreV-X.
- Those units produce results without backpressure, so each source gets a small FIFO; the FIFOs drain into a smaller number of scoreboard write ports under round-robin arbitration.
- Raises per-source almost-full stalls back to issue so that no result is ever lost in normal operation.

Parameters:
- NR_SRC, 5: result sources. Index 0=FLU, 1=load, 2=store, 3=FPU, 4=CVXIF.
- NR_WB_PORTS, 2: scoreboard write ports, 1..NR_SRC.
- FIFO_DEPTH, 2: entries per source FIFO, power of two, >=2.
- XLEN, 64: result and exception cause/tval width.
- TRANS_ID_BITS, 3: scoreboard transaction ID width.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous, active-high reset.
- flush_i  in  1  pipeline flush.
- src_valid_i  in  NR_SRC  result valid per source; always accepted, no ready.
- src_trans_id_i  in  NR_SRC x TRANS_ID_BITS  scoreboard ID.
- src_result_i  in  NR_SRC x XLEN  result data.
- src_ex_valid_i  in  NR_SRC  exception flag.
- src_ex_cause_i  in  NR_SRC x XLEN  exception cause.
- src_ex_tval_i  in  NR_SRC x XLEN  exception tval.
- src_stall_o  out  NR_SRC  almost-full; issue must not dispatch to that source.
- wb_valid_o  out  NR_WB_PORTS  write-port valid.
- wb_trans_id_o  out  NR_WB_PORTS x TRANS_ID_BITS.
- wb_result_o  out  NR_WB_PORTS x XLEN.
- wb_ex_valid_o  out  NR_WB_PORTS.
- wb_ex_cause_o  out  NR_WB_PORTS x XLEN.
- wb_ex_tval_o  out  NR_WB_PORTS x XLEN.
- overflow_o  out  1  sticky: a push hit a full FIFO.

Behaviour:
- Reset (rst_i high at clock edge, dominates flush_i):
  - all FIFOs empty; rr_ptr=0; overflow_o=0.
  - all wb_* outputs=0; src_stall_o=0.
  - Reset asserted mid-drain discards all content.
- Enqueue: at each edge, every source with src_valid_i=1 pushes {trans_id, result, ex_valid, cause, tval} into its FIFO.
- Latency: a result pushed at edge N is visible on a wb port no earlier than the cycle after edge N (1 cycle minimum). Results never bypass the FIFO.
- Drain: wb outputs are combinational from FIFO heads. The scoreboard always accepts; every head shown with wb_valid_o=1 is popped at the next edge.
- Arbitration:
  - Scan sources in order rr_ptr, rr_ptr+1, ... mod NR_SRC.
  - The k-th non-empty source found drives port k, for k < NR_WB_PORTS.
  - Unused ports: wb_valid_o=0, all data fields 0.
  - rr_ptr update: if any grant, rr_ptr <= (last granted index + 1) mod NR_SRC; otherwise unchanged.
  - A source occupies at most one port per cycle.
- Ordering: per-source FIFO order is preserved. No ordering is guaranteed across sources.
- Counts: each FIFO keeps count 0..FIFO_DEPTH; wrapping read/write pointers of log2(FIFO_DEPTH) bits.
  - Push+pop same cycle: count unchanged, legal even when full.
  - Push to full without pop: data dropped, FIFO unchanged, overflow_o <= 1 until reset.
- Stall: src_stall_o[i] = (count_i >= FIFO_DEPTH-1), registered state only. This gives issue one cycle of slack for a result already in flight.
- Flush (flush_i=1):
  - all counts, pointers and rr_ptr cleared at the edge.
  - Same-cycle pushes are discarded; same-cycle outputs are still presented but must be ignored by the scoreboard.
  - overflow_o is not cleared.
- Exception fields pass through unmodified; cause/tval are zero when ex_valid=0 at the source.

Test Plan:
- Reset then a single FLU push (trans_id=3, result=0xDEAD), nothing else → next cycle wb_valid_o=01, port0 trans_id=3 result=0xDEAD; the cycle after, wb_valid_o=00.
- All 5 sources push once in the same cycle, rr_ptr=0, 2 ports → drain in 3 cycles:
  - ports carry (0,1), then (2,3), then (4,–).
  - rr_ptr sequence 0→2→4→0.
- Load source pushes every cycle while 4 other sources also stream → src_stall_o[1] rises when count reaches 1; count never exceeds 2; overflow_o stays 0.
- Push to a full FPU FIFO with all other sources saturating the ports so no pop occurs → new entry dropped, overflow_o=1, FIFO head unchanged.
- Flush with 3 entries pending plus one same-cycle push → next cycle all wb_valid_o=0, src_stall_o=0, rr_ptr=0; overflow_o keeps its prior value.
- Store result with ex_valid=1, cause=0x7, tval=0x8000_0010 → emerges on a port with identical exception fields.

Source files
------------

// File: rtl/wb_collector.sv
// Writeback collector: per-source result FIFOs drained round-robin onto the scoreboard write ports.
// Latency: a result pushed at edge N is offered no earlier than the cycle after N (never bypasses the FIFO).
// Backpressure: sources have no ready; src_stall_o warns issue at count>=DEPTH-1, overflow_o records drops.

module wb_collector_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 8
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_flush,
  input  logic                   i_push,
  input  logic [WIDTH-1:0]       i_dat,
  input  logic                   i_pop,
  output logic [WIDTH-1:0]       o_dat,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_count,
  output logic                   o_ovf
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [AW:0]      r_cnt;
  logic             w_full;
  logic             w_pop;
  logic             w_push;

  assign w_full  = (r_cnt == (AW+1)'(DEPTH));
  assign o_empty = (r_cnt == '0);
  assign o_count = r_cnt;
  assign o_dat   = r_mem[r_rptr];
  assign w_pop   = i_pop && !o_empty;
  // A pop in the same cycle frees the slot, so push-while-full is legal then.
  assign w_push  = i_push && (!w_full || w_pop);
  assign o_ovf   = i_push && w_full && !w_pop;

  // Pointer and occupancy update; reset and flush both empty the queue.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_flush) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      if (w_push && !w_pop)      r_cnt <= r_cnt + 1'b1;
      else if (!w_push && w_pop) r_cnt <= r_cnt - 1'b1;
    end
  end

  // Entry storage; contents are only meaningful below the count, so no reset is needed.
  always_ff @(posedge i_clk) begin
    if (w_push && !i_rst && !i_flush) r_mem[r_wptr] <= i_dat;
  end
endmodule

module wb_collector #(
  parameter int NR_SRC        = 5,
  parameter int NR_WB_PORTS   = 2,
  parameter int FIFO_DEPTH    = 2,
  parameter int XLEN          = 64,
  parameter int TRANS_ID_BITS = 3
) (
  input  logic                                      clk_i,
  input  logic                                      rst_i,
  input  logic                                      flush_i,
  input  logic [NR_SRC-1:0]                         src_valid_i,
  input  logic [NR_SRC-1:0][TRANS_ID_BITS-1:0]      src_trans_id_i,
  input  logic [NR_SRC-1:0][XLEN-1:0]               src_result_i,
  input  logic [NR_SRC-1:0]                         src_ex_valid_i,
  input  logic [NR_SRC-1:0][XLEN-1:0]               src_ex_cause_i,
  input  logic [NR_SRC-1:0][XLEN-1:0]               src_ex_tval_i,
  output logic [NR_SRC-1:0]                         src_stall_o,
  output logic [NR_WB_PORTS-1:0]                    wb_valid_o,
  output logic [NR_WB_PORTS-1:0][TRANS_ID_BITS-1:0] wb_trans_id_o,
  output logic [NR_WB_PORTS-1:0][XLEN-1:0]          wb_result_o,
  output logic [NR_WB_PORTS-1:0]                    wb_ex_valid_o,
  output logic [NR_WB_PORTS-1:0][XLEN-1:0]          wb_ex_cause_o,
  output logic [NR_WB_PORTS-1:0][XLEN-1:0]          wb_ex_tval_o,
  output logic                                      overflow_o
);
  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int RR_W = (NR_SRC > 1) ? $clog2(NR_SRC) : 1;
  localparam int PW   = (NR_WB_PORTS > 1) ? $clog2(NR_WB_PORTS) : 1;

  typedef struct packed {
    logic [TRANS_ID_BITS-1:0] trans_id;
    logic [XLEN-1:0]          result;
    logic                     ex_valid;
    logic [XLEN-1:0]          ex_cause;
    logic [XLEN-1:0]          ex_tval;
  } wb_ent_t;

  wb_ent_t [NR_SRC-1:0]      w_push_dat;
  wb_ent_t [NR_SRC-1:0]      w_head;
  logic    [NR_SRC-1:0]      w_empty;
  logic    [NR_SRC-1:0][AW:0] w_count;
  logic    [NR_SRC-1:0]      w_ovf;
  logic    [NR_SRC-1:0]      w_grant;
  logic    [NR_WB_PORTS-1:0] w_wb_vld;
  wb_ent_t [NR_WB_PORTS-1:0] w_wb_dat;
  logic                      w_any;
  logic    [RR_W-1:0]        w_last;
  logic    [RR_W-1:0]        r_rr_ptr;
  logic                      r_overflow;

  for (genvar i = 0; i < NR_SRC; i++) begin : g_src
    assign w_push_dat[i] = '{trans_id: src_trans_id_i[i], result: src_result_i[i],
                             ex_valid: src_ex_valid_i[i], ex_cause: src_ex_cause_i[i],
                             ex_tval:  src_ex_tval_i[i]};

    wb_collector_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH ($bits(wb_ent_t))
    ) u_fifo (
      .i_clk   (clk_i),
      .i_rst   (rst_i),
      .i_flush (flush_i),
      .i_push  (src_valid_i[i]),
      .i_dat   (w_push_dat[i]),
      .i_pop   (w_grant[i]),
      .o_dat   (w_head[i]),
      .o_empty (w_empty[i]),
      .o_count (w_count[i]),
      .o_ovf   (w_ovf[i])
    );

    // One slot of slack covers a result already issued when the stall is seen.
    assign src_stall_o[i] = (w_count[i] >= (AW+1)'(FIFO_DEPTH-1));
  end

  // Round-robin scan from r_rr_ptr: the k-th non-empty source drives port k and is popped at the edge.
  always_comb begin
    logic [RR_W:0] w_scan_idx;
    logic [PW:0]   w_port_n;
    w_grant    = '0;
    w_wb_vld   = '0;
    w_wb_dat   = '0;
    w_any      = 1'b0;
    w_last     = '0;
    w_port_n   = '0;
    w_scan_idx = '0;
    for (int k = 0; k < NR_SRC; k++) begin
      w_scan_idx = {1'b0, r_rr_ptr} + (RR_W+1)'(k);
      if (w_scan_idx >= (RR_W+1)'(NR_SRC)) w_scan_idx = w_scan_idx - (RR_W+1)'(NR_SRC);
      if (!w_empty[w_scan_idx[RR_W-1:0]] && (w_port_n < (PW+1)'(NR_WB_PORTS))) begin
        w_grant[w_scan_idx[RR_W-1:0]]  = 1'b1;
        w_wb_vld[w_port_n[PW-1:0]]     = 1'b1;
        w_wb_dat[w_port_n[PW-1:0]]     = w_head[w_scan_idx[RR_W-1:0]];
        w_last                         = w_scan_idx[RR_W-1:0];
        w_any                          = 1'b1;
        w_port_n                       = w_port_n + 1'b1;
      end
    end
  end

  // Arbitration pointer follows the last granted source; sticky overflow survives flush.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_rr_ptr   <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (flush_i)    r_rr_ptr <= '0;
      else if (w_any) r_rr_ptr <= (w_last == RR_W'(NR_SRC-1)) ? '0 : w_last + 1'b1;
      if (!flush_i && (|w_ovf)) r_overflow <= 1'b1;
    end
  end

  assign wb_valid_o = w_wb_vld;
  assign overflow_o = r_overflow;

  for (genvar p = 0; p < NR_WB_PORTS; p++) begin : g_port
    assign wb_trans_id_o[p] = w_wb_dat[p].trans_id;
    assign wb_result_o[p]   = w_wb_dat[p].result;
    assign wb_ex_valid_o[p] = w_wb_dat[p].ex_valid;
    assign wb_ex_cause_o[p] = w_wb_dat[p].ex_cause;
    assign wb_ex_tval_o[p]  = w_wb_dat[p].ex_tval;
  end
endmodule

// File: tb/tb_wb_collector.sv
// Bench for wb_collector: directed scenarios plus randomized streams against a queue-level reference.
// Latency: inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
// Backpressure: the issue model honours src_stall_o except where overflow is provoked on purpose.

module tb_wb_collector;
  localparam int NS = 5;
  localparam int NP = 2;
  localparam int D  = 2;
  localparam int XL = 64;
  localparam int TB = 3;

  logic clk = 1'b0;
  logic rst_i;
  logic flush_i;
  logic [NS-1:0]         src_valid_i;
  logic [NS-1:0][TB-1:0] src_trans_id_i;
  logic [NS-1:0][XL-1:0] src_result_i;
  logic [NS-1:0]         src_ex_valid_i;
  logic [NS-1:0][XL-1:0] src_ex_cause_i;
  logic [NS-1:0][XL-1:0] src_ex_tval_i;
  logic [NS-1:0]         src_stall_o;
  logic [NP-1:0]         wb_valid_o;
  logic [NP-1:0][TB-1:0] wb_trans_id_o;
  logic [NP-1:0][XL-1:0] wb_result_o;
  logic [NP-1:0]         wb_ex_valid_o;
  logic [NP-1:0][XL-1:0] wb_ex_cause_o;
  logic [NP-1:0][XL-1:0] wb_ex_tval_o;
  logic                  overflow_o;

  always #5 clk = ~clk;

  wb_collector #(
    .NR_SRC(NS), .NR_WB_PORTS(NP), .FIFO_DEPTH(D), .XLEN(XL), .TRANS_ID_BITS(TB)
  ) dut (
    .clk_i(clk), .rst_i(rst_i), .flush_i(flush_i),
    .src_valid_i(src_valid_i), .src_trans_id_i(src_trans_id_i), .src_result_i(src_result_i),
    .src_ex_valid_i(src_ex_valid_i), .src_ex_cause_i(src_ex_cause_i), .src_ex_tval_i(src_ex_tval_i),
    .src_stall_o(src_stall_o), .wb_valid_o(wb_valid_o), .wb_trans_id_o(wb_trans_id_o),
    .wb_result_o(wb_result_o), .wb_ex_valid_o(wb_ex_valid_o), .wb_ex_cause_o(wb_ex_cause_o),
    .wb_ex_tval_o(wb_ex_tval_o), .overflow_o(overflow_o)
  );

  int n_err = 0;
  int n_chk = 0;

  // Reference model: each source is a bounded list of pending results, head at index 0.
  typedef struct packed {
    logic [TB-1:0] tid;
    logic [XL-1:0] res;
    logic          exv;
    logic [XL-1:0] cause;
    logic [XL-1:0] tval;
  } ent_t;

  ent_t          m_mem [NS][D];
  int            m_cnt [NS];
  int            m_rr;
  int            m_last;
  logic          m_ovf;
  logic [NS-1:0] m_grant;

  logic [NP-1:0]         e_vld;
  logic [NP-1:0][TB-1:0] e_tid;
  logic [NP-1:0][XL-1:0] e_res;
  logic [NP-1:0]         e_exv;
  logic [NP-1:0][XL-1:0] e_cause;
  logic [NP-1:0][XL-1:0] e_tval;
  logic [NS-1:0]         e_stall;
  logic                  e_ovf;

  // Expected outputs for the current cycle from the pending lists.
  function automatic void predict();
    int n;
    int idx;
    e_vld = '0; e_tid = '0; e_res = '0; e_exv = '0; e_cause = '0; e_tval = '0;
    m_grant = '0;
    m_last = -1;
    n = 0;
    for (int k = 0; k < NS; k++) begin
      idx = (m_rr + k) % NS;
      if (m_cnt[idx] > 0 && n < NP) begin
        e_vld[n]   = 1'b1;
        e_tid[n]   = m_mem[idx][0].tid;
        e_res[n]   = m_mem[idx][0].res;
        e_exv[n]   = m_mem[idx][0].exv;
        e_cause[n] = m_mem[idx][0].cause;
        e_tval[n]  = m_mem[idx][0].tval;
        m_grant[idx] = 1'b1;
        m_last = idx;
        n++;
      end
    end
    for (int i = 0; i < NS; i++) e_stall[i] = (m_cnt[i] >= D - 1);
    e_ovf = m_ovf;
  endfunction

  // Advance the model across one rising edge using the inputs currently driven.
  function automatic void commit(input logic r, input logic f);
    if (r) begin
      for (int i = 0; i < NS; i++) m_cnt[i] = 0;
      m_rr = 0;
      m_ovf = 1'b0;
    end else if (f) begin
      for (int i = 0; i < NS; i++) m_cnt[i] = 0;
      m_rr = 0;
    end else begin
      for (int i = 0; i < NS; i++) begin
        if (m_grant[i]) begin
          for (int j = 0; j < D - 1; j++) m_mem[i][j] = m_mem[i][j+1];
          m_cnt[i]--;
        end
      end
      if (m_last >= 0) m_rr = (m_last + 1) % NS;
      for (int i = 0; i < NS; i++) begin
        if (src_valid_i[i]) begin
          if (m_cnt[i] < D) begin
            m_mem[i][m_cnt[i]] = '{tid: src_trans_id_i[i], res: src_result_i[i], exv: src_ex_valid_i[i],
                                   cause: src_ex_cause_i[i], tval: src_ex_tval_i[i]};
            m_cnt[i]++;
          end else begin
            m_ovf = 1'b1;
          end
        end
      end
    end
  endfunction

  task automatic drive(input logic [NS-1:0] v);
    for (int i = 0; i < NS; i++) begin
      src_valid_i[i]    = v[i];
      src_trans_id_i[i] = TB'($urandom);
      src_result_i[i]   = {$urandom, $urandom};
      src_ex_valid_i[i] = 1'($urandom);
      src_ex_cause_i[i] = src_ex_valid_i[i] ? {$urandom, $urandom} : '0;
      src_ex_tval_i[i]  = src_ex_valid_i[i] ? {$urandom, $urandom} : '0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    flush_i = 1'b0;
    drive('0);
    @(posedge clk);
    commit(1'b1, 1'b0);
    #1;
    rst_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    flush_i = 1'b1;
    drive('1);
    @(posedge clk);
    commit(1'b1, 1'b0);
    #1;
    rst_i = 1'b0;
    flush_i = 1'b0;
    drive('0);
    @(negedge clk);
    n_chk++; if (wb_valid_o !== '0) begin n_err++; $display("FAIL reset_vld: got %b want 00", wb_valid_o); end
    n_chk++; if ({wb_trans_id_o, wb_result_o, wb_ex_valid_o, wb_ex_cause_o, wb_ex_tval_o} !== '0) begin
      n_err++; $display("FAIL reset_data: tid=%h res=%h want all zero", wb_trans_id_o, wb_result_o);
    end
    n_chk++; if (src_stall_o !== '0) begin n_err++; $display("FAIL reset_stall: got %b want 00000", src_stall_o); end
    n_chk++; if (overflow_o !== 1'b0) begin n_err++; $display("FAIL reset_ovf: got %b want 0", overflow_o); end
  endtask

  task automatic test_single_flu();
    do_reset();
    drive(5'b00001);
    src_trans_id_i[0] = 3'd3;
    src_result_i[0]   = 64'hDEAD;
    @(negedge clk);
    n_chk++; if (wb_valid_o !== 2'b00) begin n_err++; $display("FAIL flu_no_bypass: got %b want 00", wb_valid_o); end
    tick();
    drive('0);
    @(negedge clk);
    n_chk++; if (wb_valid_o !== 2'b01) begin n_err++; $display("FAIL flu_vld: got %b want 01", wb_valid_o); end
    n_chk++; if (wb_trans_id_o[0] !== 3'd3 || wb_result_o[0] !== 64'hDEAD) begin
      n_err++; $display("FAIL flu_data: got tid=%0d res=%h want tid=3 res=dead", wb_trans_id_o[0], wb_result_o[0]);
    end
    n_chk++; if (wb_trans_id_o[1] !== '0 || wb_result_o[1] !== '0) begin
      n_err++; $display("FAIL flu_unused_port: got tid=%0d res=%h want 0", wb_trans_id_o[1], wb_result_o[1]);
    end
    tick();
    @(negedge clk);
    n_chk++; if (wb_valid_o !== 2'b00) begin n_err++; $display("FAIL flu_drained: got %b want 00", wb_valid_o); end
  endtask

  task automatic test_all_five();
    logic [1:0]    xv [4] = '{2'b11, 2'b11, 2'b01, 2'b00};
    int            xt0 [4] = '{0, 2, 4, 0};
    int            xt1 [4] = '{1, 3, 0, 0};
    logic [NS-1:0] xs [4] = '{5'b11111, 5'b11100, 5'b10000, 5'b00000};
    logic [XL-1:0] r0;
    logic [XL-1:0] r1;
    do_reset();
    drive('1);
    for (int i = 0; i < NS; i++) begin
      src_trans_id_i[i] = TB'(i);
      src_result_i[i]   = 64'(256 + i);
    end
    tick();
    drive('0);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      r0 = xv[c][0] ? 64'(256 + xt0[c]) : '0;
      r1 = xv[c][1] ? 64'(256 + xt1[c]) : '0;
      n_chk++; if (wb_valid_o !== xv[c] || wb_trans_id_o[0] !== TB'(xt0[c]) || wb_trans_id_o[1] !== TB'(xt1[c])) begin
        n_err++; $display("FAIL all_five_c%0d: got vld=%b tid=%0d,%0d want vld=%b tid=%0d,%0d",
                          c, wb_valid_o, wb_trans_id_o[0], wb_trans_id_o[1], xv[c], xt0[c], xt1[c]);
      end
      n_chk++; if (wb_result_o[0] !== r0 || wb_result_o[1] !== r1) begin
        n_err++; $display("FAIL all_five_res_c%0d: got %h,%h want %h,%h", c, wb_result_o[0], wb_result_o[1], r0, r1);
      end
      n_chk++; if (src_stall_o !== xs[c]) begin
        n_err++; $display("FAIL all_five_stall_c%0d: got %b want %b", c, src_stall_o, xs[c]);
      end
      tick();
    end
    // Pointer must have wrapped to 0, so FLU wins port 0 over the CVXIF source.
    drive(5'b10101);
    for (int i = 0; i < NS; i++) src_trans_id_i[i] = TB'(i);
    tick();
    drive('0);
    @(negedge clk);
    n_chk++; if (wb_valid_o !== 2'b11 || wb_trans_id_o[0] !== 3'd0 || wb_trans_id_o[1] !== 3'd2) begin
      n_err++; $display("FAIL rr_wrap: got vld=%b tid=%0d,%0d want vld=11 tid=0,2", wb_valid_o, wb_trans_id_o[0], wb_trans_id_o[1]);
    end
  endtask

  task automatic test_exception();
    do_reset();
    drive(5'b00101);
    src_trans_id_i[0] = 3'd1; src_result_i[0] = 64'h11; src_ex_valid_i[0] = 1'b0;
    src_ex_cause_i[0] = '0;   src_ex_tval_i[0] = '0;
    src_trans_id_i[2] = 3'd5; src_result_i[2] = 64'h55; src_ex_valid_i[2] = 1'b1;
    src_ex_cause_i[2] = 64'h7; src_ex_tval_i[2] = 64'h8000_0010;
    tick();
    drive('0);
    @(negedge clk);
    n_chk++; if (wb_valid_o !== 2'b11 || wb_trans_id_o[1] !== 3'd5 || wb_result_o[1] !== 64'h55) begin
      n_err++; $display("FAIL exc_port: got vld=%b tid=%0d res=%h want vld=11 tid=5 res=55", wb_valid_o, wb_trans_id_o[1], wb_result_o[1]);
    end
    n_chk++; if (wb_ex_valid_o[1] !== 1'b1 || wb_ex_cause_o[1] !== 64'h7 || wb_ex_tval_o[1] !== 64'h8000_0010) begin
      n_err++; $display("FAIL exc_fields: got exv=%b cause=%h tval=%h want 1 7 80000010", wb_ex_valid_o[1], wb_ex_cause_o[1], wb_ex_tval_o[1]);
    end
    n_chk++; if (wb_ex_valid_o[0] !== 1'b0 || wb_ex_cause_o[0] !== '0 || wb_ex_tval_o[0] !== '0) begin
      n_err++; $display("FAIL exc_clean: got exv=%b cause=%h tval=%h want 0 0 0", wb_ex_valid_o[0], wb_ex_cause_o[0], wb_ex_tval_o[0]);
    end
  endtask

  task automatic test_reset_mid_drain();
    do_reset();
    drive('1);
    tick();
    drive('0);
    tick();
    rst_i = 1'b1;
    drive('1);
    tick();
    rst_i = 1'b0;
    drive('0);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      n_chk++; if (wb_valid_o !== 2'b00 || src_stall_o !== '0) begin
        n_err++; $display("FAIL mid_reset_c%0d: got vld=%b stall=%b want 00 00000", c, wb_valid_o, src_stall_o);
      end
      tick();
    end
  endtask

  task automatic test_stall_stream();
    logic [NS-1:0] mask;
    do_reset();
    for (int c = 0; c < 40; c++) begin
      predict();
      mask = NS'($urandom) | 5'b00010;
      drive(mask & ~e_stall);
      @(negedge clk);
      n_chk++;
      if ({wb_valid_o, wb_trans_id_o, wb_result_o, wb_ex_valid_o, wb_ex_cause_o, wb_ex_tval_o, src_stall_o, overflow_o} !==
          {e_vld, e_tid, e_res, e_exv, e_cause, e_tval, e_stall, e_ovf}) begin
        n_err++; $display("FAIL stream_c%0d: got vld=%b tid=%h res=%h exv=%b stall=%b ovf=%b want vld=%b tid=%h res=%h exv=%b stall=%b ovf=%b",
                          c, wb_valid_o, wb_trans_id_o, wb_result_o, wb_ex_valid_o, src_stall_o, overflow_o,
                          e_vld, e_tid, e_res, e_exv, e_stall, e_ovf);
      end
      @(posedge clk);
      commit(1'b0, 1'b0);
      #1;
    end
    n_chk++; if (overflow_o !== 1'b0) begin n_err++; $display("FAIL stream_no_ovf: got %b want 0", overflow_o); end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int c = 0; c < 14; c++) begin
      predict();
      drive(c < 6 ? '1 : '0);
      @(negedge clk);
      n_chk++;
      if ({wb_valid_o, wb_trans_id_o, wb_result_o, wb_ex_valid_o, wb_ex_cause_o, wb_ex_tval_o, src_stall_o, overflow_o} !==
          {e_vld, e_tid, e_res, e_exv, e_cause, e_tval, e_stall, e_ovf}) begin
        n_err++; $display("FAIL overflow_c%0d: got vld=%b tid=%h res=%h exv=%b stall=%b ovf=%b want vld=%b tid=%h res=%h exv=%b stall=%b ovf=%b",
                          c, wb_valid_o, wb_trans_id_o, wb_result_o, wb_ex_valid_o, src_stall_o, overflow_o,
                          e_vld, e_tid, e_res, e_exv, e_stall, e_ovf);
      end
      @(posedge clk);
      commit(1'b0, 1'b0);
      #1;
    end
    n_chk++; if (overflow_o !== 1'b1) begin n_err++; $display("FAIL overflow_sticky: got %b want 1", overflow_o); end
  endtask

  task automatic test_flush();
    logic prev_ovf;
    prev_ovf = m_ovf;
    drive(5'b00111);
    tick();
    drive(5'b01000);
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    drive('0);
    @(negedge clk);
    n_chk++; if (wb_valid_o !== 2'b00 || src_stall_o !== '0) begin
      n_err++; $display("FAIL flush_clear: got vld=%b stall=%b want 00 00000", wb_valid_o, src_stall_o);
    end
    n_chk++; if (overflow_o !== prev_ovf) begin n_err++; $display("FAIL flush_ovf_kept: got %b want %b", overflow_o, prev_ovf); end
    drive(5'b10010);
    for (int i = 0; i < NS; i++) src_trans_id_i[i] = TB'(i);
    tick();
    drive('0);
    @(negedge clk);
    n_chk++; if (wb_valid_o !== 2'b11 || wb_trans_id_o[0] !== 3'd1 || wb_trans_id_o[1] !== 3'd4) begin
      n_err++; $display("FAIL flush_rr_zero: got vld=%b tid=%0d,%0d want vld=11 tid=1,4", wb_valid_o, wb_trans_id_o[0], wb_trans_id_o[1]);
    end
    tick();
    @(negedge clk);
    n_chk++; if (wb_valid_o !== 2'b00) begin n_err++; $display("FAIL flush_discard: got %b want 00", wb_valid_o); end
  endtask

  task automatic test_random();
    logic [NS-1:0] mask;
    int            r;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      predict();
      r = int'($urandom % 100);
      mask = NS'($urandom);
      if ($urandom % 4 != 0) mask = mask & ~e_stall;
      drive(mask);
      flush_i = (r < 4);
      rst_i   = (r == 99);
      @(negedge clk);
      n_chk++;
      if ({wb_valid_o, wb_trans_id_o, wb_result_o, wb_ex_valid_o, wb_ex_cause_o, wb_ex_tval_o, src_stall_o, overflow_o} !==
          {e_vld, e_tid, e_res, e_exv, e_cause, e_tval, e_stall, e_ovf}) begin
        n_err++; $display("FAIL random_c%0d: got vld=%b tid=%h res=%h exv=%b stall=%b ovf=%b want vld=%b tid=%h res=%h exv=%b stall=%b ovf=%b",
                          c, wb_valid_o, wb_trans_id_o, wb_result_o, wb_ex_valid_o, src_stall_o, overflow_o,
                          e_vld, e_tid, e_res, e_exv, e_stall, e_ovf);
      end
      @(posedge clk);
      commit(rst_i, flush_i);
      #1;
    end
    rst_i = 1'b0;
    flush_i = 1'b0;
  endtask

  initial begin
    rst_i = 1'b1;
    flush_i = 1'b0;
    drive('0);
    test_reset();
    test_single_flu();
    test_all_five();
    test_exception();
    test_reset_mid_drain();
    test_stall_stream();
    test_overflow();
    test_flush();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
